button_array: RTL and testbench

- Input-side counterpart of the LED output path: samples the 18 physical mole-hit button pins and debounces them.
- Converts presses into a queue of button-index events that the processor drains through a pop handshake.
- Sits beside the LED array at the top level, between the button pins and the processor's input ports.
- Gives the game loop an ordered, lossless-until-full record of hits plus a live debounced state vector.

---
 rtl/button_array.sv | 174 +++++++++++++++++
 tb/tb_button_array.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_array.sv
// button_array: 2-flop sync, tick-sampled debounce, lowest-index arbiter into a FWFT event FIFO.
// Press reaches the FIFO head 2 cycles after the debounced rise; on a full FIFO, pending bits are held. The BUTTON_RELEASE_EVENTS_EN macro adds release events.
module button_array #(
   parameter int NUM_BUTTONS      = 18,
   parameter int IDX_W            = 5,
   parameter int TICK_DIV         = 50000,
   parameter int DEBOUNCE_SAMPLES = 4,
   parameter int FIFO_DEPTH       = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_BUTTONS-1:0]        button_pins,
   output logic [NUM_BUTTONS-1:0]        buttons_state,
   output logic                          event_valid,
   output logic [IDX_W-1:0]              event_index,
   output logic                          event_release,
   input  logic                          event_pop,
   output logic [$clog2(FIFO_DEPTH):0]   event_count,
   output logic                          overflow,
   input  logic                          clear_overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SAMPLES - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
`ifdef BUTTON_RELEASE_EVENTS_EN
   localparam int ENTRY_W = IDX_W + 1;
`else
   localparam int ENTRY_W = IDX_W;
`endif

   logic [NUM_BUTTONS-1:0] sync_meta, sync_q, state_prev;
   logic [NUM_BUTTONS-1:0] pending, rise, press_clr, lost;
   logic [PRE_W-1:0]       presc;
   logic                   tick;
   logic [CNT_W-1:0]       db_cnt [NUM_BUTTONS];
   logic [IDX_W-1:0]       press_idx, push_idx;
   logic                   press_any, push, push_rel, do_pop, can_accept;
   logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0]     head, push_entry;
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [PTR_W:0]         count;
`ifdef BUTTON_RELEASE_EVENTS_EN
   logic [NUM_BUTTONS-1:0] rel_pending, fall, rel_clr;
   logic [IDX_W-1:0]       rel_idx;
   logic                   rel_any;
`endif

   assign tick = (presc == PRE_LAST);
   assign rise = buttons_state & ~state_prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_meta     <= '0;
         sync_q        <= '0;
         state_prev    <= '0;
         buttons_state <= '0;
         presc         <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
      end else begin
         sync_meta  <= button_pins;
         sync_q     <= sync_meta;
         state_prev <= buttons_state;
         presc      <= tick ? '0 : presc + 1'b1;
         if (tick) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
               if (sync_q[i] == buttons_state[i]) begin
                  db_cnt[i] <= '0;
               end else if (db_cnt[i] == DB_LAST) begin
                  buttons_state[i] <= sync_q[i];
                  db_cnt[i]        <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   // Descending scan so the last hit written is the lowest set index.
   always_comb begin
      press_any = 1'b0;
      press_idx = '0;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            press_any = 1'b1;
            press_idx = IDX_W'(i);
         end
      end
   end

   assign do_pop     = event_pop && event_valid;
   assign can_accept = (count != FULL_CNT) || event_pop;

`ifdef BUTTON_RELEASE_EVENTS_EN
   assign fall = ~buttons_state & state_prev;

   always_comb begin
      rel_any = 1'b0;
      rel_idx = '0;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (rel_pending[i]) begin
            rel_any = 1'b1;
            rel_idx = IDX_W'(i);
         end
      end
   end

   assign push       = can_accept && (press_any || rel_any);
   assign push_rel   = !press_any;
   assign push_idx   = press_any ? press_idx : rel_idx;
   assign push_entry = {push_rel, push_idx};

   always_comb begin
      rel_clr = '0;
      for (int i = 0; i < NUM_BUTTONS; i++)
         rel_clr[i] = push && push_rel && (rel_idx == IDX_W'(i));
   end

   assign lost = (rise & pending & ~press_clr) | (fall & rel_pending & ~rel_clr);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rel_pending <= '0;
      else       rel_pending <= (rel_pending & ~rel_clr) | fall;
   end
`else
   assign push       = can_accept && press_any;
   assign push_rel   = 1'b0;
   assign push_idx   = press_idx;
   assign push_entry = push_idx;
   assign lost       = rise & pending & ~press_clr;
`endif

   always_comb begin
      press_clr = '0;
      for (int i = 0; i < NUM_BUTTONS; i++)
         press_clr[i] = push && !push_rel && (press_idx == IDX_W'(i));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         pending <= (pending & ~press_clr) | rise;
         if (|lost)               overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_pop)      count <= count + 1'b1;
         else if (!push && do_pop) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: the head is gated by event_valid.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

   assign head        = mem[rd_ptr];
   assign event_valid = (count != '0);
   assign event_index = event_valid ? head[IDX_W-1:0] : '0;
   assign event_count = count;
`ifdef BUTTON_RELEASE_EVENTS_EN
   assign event_release = event_valid & head[IDX_W];
`else
   assign event_release = 1'b0;
`endif
endmodule

// File: tb/tb_button_array.sv
// Bench for button_array: directed scenarios plus random pin/pop traffic against a queue-based model.
module tb_button_array;
   localparam int N  = 18;
   localparam int IW = 5;
   localparam int TD = 4;
   localparam int DS = 2;
   localparam int FD = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  button_pins = '0;
   logic          event_pop = 1'b0;
   logic          clear_overflow = 1'b0;
   logic [N-1:0]  buttons_state;
   logic          event_valid;
   logic [IW-1:0] event_index;
   logic          event_release;
   logic [2:0]    event_count;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   button_array #(
      .NUM_BUTTONS(N), .IDX_W(IW), .TICK_DIV(TD), .DEBOUNCE_SAMPLES(DS), .FIFO_DEPTH(FD)
   ) dut (
      .clock(clock), .reset(reset), .button_pins(button_pins),
      .buttons_state(buttons_state), .event_valid(event_valid), .event_index(event_index),
      .event_release(event_release), .event_pop(event_pop), .event_count(event_count),
      .overflow(overflow), .clear_overflow(clear_overflow)
   );

   // Reference model: per-button pin history, disagreement run length, pending flags
   // and a queue of events (index + 64 marks a release).
   bit m_s1[N], m_s2[N], m_st[N], m_prev[N], m_pp[N];
`ifdef BUTTON_RELEASE_EVENTS_EN
   bit m_pr[N];
`endif
   int m_run[N];
   int m_phase;
   bit m_ovf;
   int m_q[$];

   function void model_reset();
      for (int i = 0; i < N; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_prev[i] = 0; m_pp[i] = 0; m_run[i] = 0;
`ifdef BUTTON_RELEASE_EVENTS_EN
         m_pr[i] = 0;
`endif
      end
      m_phase = 0;
      m_ovf   = 0;
      m_q.delete();
   endfunction

   function void model_step();
      int g;
      bit grel, popped, sample, lost, rise, taken;
      sample = (m_phase == TD - 1);
      g = -1;
      grel = 0;
      for (int i = 0; i < N; i++) if (m_pp[i]) begin g = i; break; end
`ifdef BUTTON_RELEASE_EVENTS_EN
      if (g < 0) for (int i = 0; i < N; i++) if (m_pr[i]) begin g = i; grel = 1; break; end
`endif
      popped = event_pop && (m_q.size() > 0);
      if (m_q.size() >= FD && !popped) g = -1;
      if (popped) void'(m_q.pop_front());
      if (g >= 0) m_q.push_back(g + (grel ? 64 : 0));
      lost = 0;
      for (int i = 0; i < N; i++) begin
         rise  = m_st[i] && !m_prev[i];
         taken = (g == i) && !grel;
         if (rise && m_pp[i] && !taken) lost = 1;
         m_pp[i] = (m_pp[i] && !taken) || rise;
`ifdef BUTTON_RELEASE_EVENTS_EN
         begin
            bit fall, taken_r;
            fall    = !m_st[i] && m_prev[i];
            taken_r = (g == i) && grel;
            if (fall && m_pr[i] && !taken_r) lost = 1;
            m_pr[i] = (m_pr[i] && !taken_r) || fall;
         end
`endif
         m_prev[i] = m_st[i];
         if (sample) begin
            if (m_s2[i] == m_st[i]) m_run[i] = 0;
            else begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == DS) begin m_st[i] = m_s2[i]; m_run[i] = 0; end
            end
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = button_pins[i];
      end
      if (lost) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
      m_phase = sample ? 0 : m_phase + 1;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] es;
      for (int i = 0; i < N; i++) es[i] = m_st[i];
      check("state",    buttons_state, es);
      check("valid",    event_valid,   m_q.size() > 0);
      check("index",    event_index,   (m_q.size() > 0) ? m_q[0] % 64 : 0);
      check("release",  event_release, (m_q.size() > 0) ? m_q[0] / 64 : 0);
      check("count",    event_count,   m_q.size());
      check("overflow", overflow,      m_ovf);
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
      compare_all();
   endtask

   task automatic pop_expect(input string tag, input int idx, input bit rel);
      check(tag, event_valid, 1);
      check(tag, event_index, idx);
      check(tag, event_release, rel);
      event_pop = 1'b1;
      cyc();
      event_pop = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && event_valid; k++) begin
         event_pop = 1'b1;
         cyc();
      end
      event_pop = 1'b0;
      cyc();
      check("drain_empty", event_valid, 0);
   endtask

   int full_list[6] = '{1, 2, 4, 6, 8, 10};

   initial begin
      repeat (3) cyc();
      check("rst_state", buttons_state, 0);
      check("rst_valid", event_valid, 0);
      check("rst_count", event_count, 0);
      check("rst_ovf",   overflow, 0);
      reset = 1'b0;
      repeat (100) cyc();
      check("idle_valid", event_valid, 0);

      // single press, then pop
      button_pins[5] = 1'b1;
      for (int k = 0; k < 14 && !buttons_state[5]; k++) cyc();
      check("press5_state", buttons_state[5], 1);
      repeat (2) cyc();
      check("press5_count", event_count, 1);
      pop_expect("press5_pop", 5, 0);
      check("press5_empty", event_valid, 0);
      button_pins[5] = 1'b0;
      repeat (20) cyc();
      drain();
      event_pop = 1'b1;
      cyc();
      event_pop = 1'b0;
      check("pop_empty_count", event_count, 0);

      // glitch positioned so its window spans only one sample tick
      while (m_phase == 1) cyc();
      button_pins[3] = 1'b1;
      repeat (5) cyc();
      button_pins[3] = 1'b0;
      repeat (20) cyc();
      check("glitch_state", buttons_state[3], 0);
      check("glitch_valid", event_valid, 0);

      // simultaneous presses
      button_pins[0] = 1'b1; button_pins[7] = 1'b1; button_pins[17] = 1'b1;
      for (int k = 0; k < 30 && event_count < 3; k++) cyc();
      check("simul_count", event_count, 3);
      pop_expect("simul_0", 0, 0);
      pop_expect("simul_7", 7, 0);
      pop_expect("simul_17", 17, 0);
      button_pins = '0;
      repeat (20) cyc();
      drain();

      // full FIFO, held pending bits, lost press
      foreach (full_list[j]) button_pins[full_list[j]] = 1'b1;
      repeat (20) cyc();
      check("full_count", event_count, 4);
      check("full_ovf", overflow, 0);
      button_pins = '0;
      repeat (20) cyc();
      button_pins[10] = 1'b1;
      repeat (16) cyc();
      check("lost_ovf", overflow, 1);
      clear_overflow = 1'b1;
      cyc();
      clear_overflow = 1'b0;
      check("clr_ovf", overflow, 0);
      foreach (full_list[j]) pop_expect("full_order", full_list[j], 0);
      button_pins = '0;
      repeat (20) cyc();
      drain();

      // press then release
      button_pins[9] = 1'b1;
      repeat (16) cyc();
      button_pins[9] = 1'b0;
      repeat (16) cyc();
      pop_expect("rel_press", 9, 0);
`ifdef BUTTON_RELEASE_EVENTS_EN
      pop_expect("rel_release", 9, 1);
`endif
      check("rel_empty", event_valid, 0);

      // random traffic with a mid-run reset
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            int b;
            b = $urandom_range(0, N - 1);
            button_pins[b] = ~button_pins[b];
         end
         event_pop      = ($urandom_range(0, 3) == 0);
         clear_overflow = ($urandom_range(0, 63) == 0);
         if (k == 1200) reset = 1'b1;
         if (k == 1203) reset = 1'b0;
         cyc();
      end
      event_pop = 1'b0;
      clear_overflow = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
